// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register sequencer: FSM state encoding
// and the register mode-select constants driven on sr_s.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_TOMSB = 2'b01;
  localparam logic [1:0] MODE_TOLSB = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

endpackage

// File: rtl/shift_shadow.sv
// Shadow model of the downstream bidirectional shift register. Applies the
// sequencer's own mode/data/fill outputs to a local copy every rising edge
// and raises a sticky flag if the real register disagrees at completion.
module shift_shadow
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sr_s,
  input  logic [WIDTH-1:0] sr_i,
  input  logic             sr_r,
  input  logic             cmp_en,
  input  logic [WIDTH-1:0] sr_o,
  output logic [WIDTH-1:0] exp_o,
  output logic             mismatch
);

  logic [WIDTH-1:0] exp_q, exp_d;
  logic             mismatch_q, mismatch_d;

  // Next expected contents using the register's hold/shift/load rules
  always_comb begin
    exp_d      = exp_q;
    mismatch_d = mismatch_q;
    case (sr_s)
      MODE_HOLD:  exp_d = exp_q;
      MODE_TOMSB: exp_d = {exp_q[WIDTH-2:0], sr_r};
      MODE_TOLSB: exp_d = {sr_r, exp_q[WIDTH-1:1]};
      MODE_LOAD:  exp_d = sr_i;
      default:    exp_d = exp_q;
    endcase
    if (cmp_en && (sr_o != exp_q)) begin
      mismatch_d = 1'b1;
    end
  end

  // Expected-value and sticky mismatch registers
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign exp_o    = exp_q;
  assign mismatch = mismatch_q;

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer for a bidirectional shift register: accepts one
// load-then-shift command over valid/ready, drives the register's mode,
// parallel data and serial fill, and pulses done on completion.
// Optional shadow model/comparator enabled with macro SHIFT_SHADOW_EN.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic             abort,
  output logic [1:0]       sr_s,
  output logic [WIDTH-1:0] sr_i,
  output logic             sr_r,
  output logic             busy,
  output logic             done
`ifdef SHIFT_SHADOW_EN
  ,
  input  logic [WIDTH-1:0] sr_o,
  output logic [WIDTH-1:0] exp_o,
  output logic             mismatch
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_i_q, sr_i_d;
  logic             sr_r_q, sr_r_d;
  logic [1:0]       sr_s_q, sr_s_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_w;

  // Abort outranks acceptance, so ready drops combinationally with abort
  assign ready_w = (state_q == IDLE) && !abort;

  // Next-state and next-output logic; outputs are derived from the next
  // state so every output is a flop that is valid for the whole cycle
  always_comb begin
    state_d = state_q;
    sr_i_d  = sr_i_q;
    sr_r_d  = sr_r_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_w) begin
          state_d = LOAD;
          sr_i_d  = cmd_data;
          sr_r_d  = cmd_fill;
          dir_d   = cmd_dir;
          cnt_d   = cmd_count;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          rem_d   = cnt_q;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      LOAD:    sr_s_d = MODE_LOAD;
      SHIFT:   sr_s_d = dir_d ? MODE_TOLSB : MODE_TOMSB;
      default: sr_s_d = MODE_HOLD;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, latched command and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_i_q  <= '0;
      sr_r_q  <= 1'b0;
      sr_s_q  <= MODE_HOLD;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_i_q  <= sr_i_d;
      sr_r_q  <= sr_r_d;
      sr_s_q  <= sr_s_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = ready_w;
  assign sr_s      = sr_s_q;
  assign sr_i      = sr_i_q;
  assign sr_r      = sr_r_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef SHIFT_SHADOW_EN
  shift_shadow #(
    .WIDTH(WIDTH)
  ) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .sr_s     (sr_s_q),
    .sr_i     (sr_i_q),
    .sr_r     (sr_r_q),
    .cmp_en   (state_q == DONE),
    .sr_o     (sr_o),
    .exp_o    (exp_o),
    .mismatch (mismatch)
  );
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: table of load/shift commands checked
// cycle by cycle, plus hand-written abort, abort-priority, reset and
// shadow-mismatch sequences. Shadow checks compile under SHIFT_SHADOW_EN.
module tb_shift_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_fill;
  logic             abort;
  logic [1:0]       sr_s;
  logic [WIDTH-1:0] sr_i;
  logic             sr_r;
  logic             busy;
  logic             done;
`ifdef SHIFT_SHADOW_EN
  logic [WIDTH-1:0] sr_o;
  logic [WIDTH-1:0] exp_o;
  logic             mismatch;
  logic [WIDTH-1:0] reg_q = '0;
  logic             corrupt = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_sequencer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
    .cmd_fill  (cmd_fill),
    .abort     (abort),
    .sr_s      (sr_s),
    .sr_i      (sr_i),
    .sr_r      (sr_r),
    .busy      (busy),
    .done      (done)
`ifdef SHIFT_SHADOW_EN
    ,
    .sr_o      (sr_o),
    .exp_o     (exp_o),
    .mismatch  (mismatch)
`endif
  );

`ifdef SHIFT_SHADOW_EN
  // Downstream register model: captures on the falling edge
  always @(negedge clk) begin
    case (sr_s)
      2'b01:   reg_q <= {reg_q[WIDTH-2:0], sr_r};
      2'b10:   reg_q <= {sr_r, reg_q[WIDTH-1:1]};
      2'b11:   reg_q <= sr_i;
      default: reg_q <= reg_q;
    endcase
  end
  assign sr_o = reg_q ^ {{(WIDTH-1){1'b0}}, corrupt};
`endif

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             dir;
    logic [CNT_W-1:0] count;
    logic             fill;
    logic [WIDTH-1:0] exp_reg;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Issue one command starting at a falling edge and check every cycle
  // through the first idle cycle after done; returns at a falling edge.
  task automatic run_cmd(input vec_t v, input logic exp_mm);
    int guard;
    int n;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("ready_wait", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = v.data;
    cmd_dir   = v.dir;
    cmd_count = v.count;
    cmd_fill  = v.fill;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = int'(v.count);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      chk("busy", {31'b0, busy}, 32'd1);
      chk("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
      if (k == 1) begin
        chk("load_sr_s", {30'b0, sr_s}, 32'd3);
        chk("load_sr_i", {24'b0, sr_i}, {24'b0, v.data});
        chk("load_done", {31'b0, done}, 32'd0);
      end else if (k <= n + 1) begin
        chk("shift_sr_s", {30'b0, sr_s}, v.dir ? 32'd2 : 32'd1);
        chk("shift_sr_r", {31'b0, sr_r}, {31'b0, v.fill});
        chk("shift_done", {31'b0, done}, 32'd0);
      end else begin
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("done_sr_s", {30'b0, sr_s}, 32'd0);
`ifdef SHIFT_SHADOW_EN
        chk("exp_o", {24'b0, exp_o}, {24'b0, v.exp_reg});
`endif
      end
    end
    @(negedge clk);
    chk("post_busy", {31'b0, busy}, 32'd0);
    chk("post_done", {31'b0, done}, 32'd0);
    chk("post_ready", {31'b0, cmd_ready}, 32'd1);
    chk("post_sr_s", {30'b0, sr_s}, 32'd0);
    chk("post_sr_i_hold", {24'b0, sr_i}, {24'b0, v.data});
    chk("post_sr_r_hold", {31'b0, sr_r}, {31'b0, v.fill});
`ifdef SHIFT_SHADOW_EN
    chk("post_mismatch", {31'b0, mismatch}, {31'b0, exp_mm});
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sr_s"}, {30'b0, sr_s}, 32'd0);
    chk({tag, "_sr_i"}, {24'b0, sr_i}, 32'd0);
    chk({tag, "_sr_r"}, {31'b0, sr_r}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_ready"}, {31'b0, cmd_ready}, 32'd1);
`ifdef SHIFT_SHADOW_EN
    chk({tag, "_exp_o"}, {24'b0, exp_o}, 32'd0);
    chk({tag, "_mismatch"}, {31'b0, mismatch}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    vec_t v;
    vecs[0] = '{data: 8'hA5, dir: 1'b0, count: 4'd0,  fill: 1'b0, exp_reg: 8'hA5};
    vecs[1] = '{data: 8'h81, dir: 1'b0, count: 4'd3,  fill: 1'b1, exp_reg: 8'h0F};
    vecs[2] = '{data: 8'h81, dir: 1'b1, count: 4'd2,  fill: 1'b0, exp_reg: 8'h20};
    vecs[3] = '{data: 8'h00, dir: 1'b0, count: 4'd12, fill: 1'b1, exp_reg: 8'hFF};
    vecs[4] = '{data: 8'hC3, dir: 1'b1, count: 4'd1,  fill: 1'b1, exp_reg: 8'hE1};

    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_data = '0; cmd_dir = 1'b0; cmd_count = '0; cmd_fill = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // Table of commands, issued back to back at minimum spacing
    for (int i = 0; i < 5; i++) begin
      run_cmd(vecs[i], 1'b0);
    end

    // Abort priority in IDLE: ready low, offered command not taken
    abort = 1'b1; cmd_valid = 1'b1; cmd_data = 8'h11; cmd_count = 4'd1;
    #1 chk("abort_blocks_ready", {31'b0, cmd_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_accept_busy", {31'b0, busy}, 32'd0);
    chk("abort_no_accept_sr_s", {30'b0, sr_s}, 32'd0);
    abort = 1'b0; cmd_valid = 1'b0;
    #1 chk("abort_release_ready", {31'b0, cmd_ready}, 32'd1);

    // Abort in the second SHIFT cycle, new command accepted right after
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 8'h55; cmd_dir = 1'b0; cmd_count = 4'd5; cmd_fill = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("ab_load_sr_s", {30'b0, sr_s}, 32'd3);
    @(negedge clk);
    chk("ab_shift1_sr_s", {30'b0, sr_s}, 32'd1);
    @(negedge clk);
    chk("ab_shift2_sr_s", {30'b0, sr_s}, 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    cmd_valid = 1'b1; cmd_data = 8'h3C; cmd_dir = 1'b1; cmd_count = 4'd1; cmd_fill = 1'b1;
    @(negedge clk);
    chk("ab_idle_sr_s", {30'b0, sr_s}, 32'd0);
    chk("ab_idle_done", {31'b0, done}, 32'd0);
    chk("ab_idle_busy", {31'b0, busy}, 32'd0);
    chk("ab_idle_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("ab_new_load_sr_s", {30'b0, sr_s}, 32'd3);
    chk("ab_new_load_sr_i", {24'b0, sr_i}, 32'h3C);
    @(negedge clk);
    chk("ab_new_shift_sr_s", {30'b0, sr_s}, 32'd2);
    chk("ab_new_shift_sr_r", {31'b0, sr_r}, 32'd1);
    @(negedge clk);
    chk("ab_new_done", {31'b0, done}, 32'd1);
`ifdef SHIFT_SHADOW_EN
    chk("ab_new_exp_o", {24'b0, exp_o}, 32'h9E);
`endif
    @(negedge clk);
    chk("ab_new_post_ready", {31'b0, cmd_ready}, 32'd1);

    // Reset during SHIFT
    cmd_valid = 1'b1; cmd_data = 8'hF0; cmd_dir = 1'b0; cmd_count = 4'd6; cmd_fill = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_sr_s", {30'b0, sr_s}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst_mid");
    reset = 1'b0;

`ifdef SHIFT_SHADOW_EN
    // Wrong register readback sets a sticky mismatch cleared only by reset
    @(negedge clk);
    corrupt = 1'b1;
    run_cmd(vecs[0], 1'b1);
    corrupt = 1'b0;
    run_cmd(vecs[2], 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mismatch_cleared", {31'b0, mismatch}, 32'd0);
    reset = 1'b0;
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
